apb4_slave: RTL and testbench

APB4 (AMBA 3/4 APB) completer with an internal word-organised register memory, used as the design under test of the APB4 slave verification environment. It samples requester signals on the rising edge of `PCLK`, executes single read/write transfers with byte strobes, and reports out-of-range or misaligned accesses through `PSLVERR`. One instance sits on the APB bus driven by the testbench requester.

---
 rtl/apb4_pkg.sv | 14 +
 rtl/apb4_mem.sv | 36 +++
 rtl/apb4_slave.sv | 144 ++++++++++++++
 tb/tb_apb4_slave.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_pkg.sv
// Shared types and widths for the APB4 completer and its bench.
package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_DATA_W    = 32;
  localparam int APB_STRB_W    = 4;
  localparam int APB_MEM_DEPTH = 256;

endpackage

// File: rtl/apb4_mem.sv
// Byte-strobed word memory: synchronous write, combinational read, cleared on reset.
module apb4_mem
  import apb4_pkg::*;
#(
  parameter int DEPTH = APB_MEM_DEPTH,
  parameter int IDX_W = $clog2(APB_MEM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [APB_STRB_W-1:0] wstrb_i,
  input  logic [APB_DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [APB_DATA_W-1:0] rdata_o
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/apb4_slave.sv
// APB4 completer over a word memory with byte strobes and PSLVERR on bad addresses.
// Optional wait states are enabled by defining APB_WAIT_STATE_EN.
//
// state  | meaning
// IDLE   | no transfer held; waiting for a setup phase on the bus
// SETUP  | setup phase captured on the last edge; bus is in its first access cycle
// ACCESS | access phase extended by wait states, PREADY not yet raised
module apb4_slave
  import apb4_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = APB_DATA_W,
  parameter int MEM_DEPTH   = APB_MEM_DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [APB_STRB_W-1:0] PSTRB,
  input  logic [2:0]            PPROT,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  apb_state_e            state_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  err_q;
  logic                  write_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;

  logic                  setup_s;
  logic                  access_s;
  logic [ADDR_WIDTH-3:0] req_idx;
  logic                  req_err;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  mem_we;
  logic                  setup_ready;
  logic                  wait_done;
  logic                  unused_prot;

  assign unused_prot = ^PPROT;

  assign setup_s  = PSEL && !PENABLE;
  assign access_s = PSEL && PENABLE && (state_q != IDLE);
  assign req_idx  = PADDR[ADDR_WIDTH-1:2];
  assign req_err  = (PADDR[1:0] != 2'b00) || (req_idx >= (ADDR_WIDTH-2)'(MEM_DEPTH));
  // Zero-wait reads must fetch from the live address while the setup phase is on the bus.
  assign rd_idx   = setup_s ? req_idx[IDX_W-1:0] : idx_q;
  assign mem_we   = access_s && pready_q && write_q && !err_q;

`ifdef APB_WAIT_STATE_EN
  localparam int WAIT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_q <= '0;
    end else if (setup_s) begin
      wait_q <= WAIT_W'(WAIT_CYCLES);
    end else if (access_s && !pready_q && (wait_q != '0)) begin
      wait_q <= wait_q - 1'b1;
    end
  end

  assign setup_ready = (WAIT_CYCLES == 0);
  assign wait_done   = (wait_q <= WAIT_W'(1));
`else
  logic unused_wait_cfg;

  assign unused_wait_cfg = (WAIT_CYCLES != 0);
  assign setup_ready     = 1'b1;
  assign wait_done       = 1'b1;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      if (setup_s) begin
        state_q <= SETUP;
        idx_q   <= req_idx[IDX_W-1:0];
        err_q   <= req_err;
        write_q <= PWRITE;
        if (setup_ready) begin
          pready_q  <= 1'b1;
          pslverr_q <= req_err;
          prdata_q  <= (req_err || PWRITE) ? '0 : rd_data;
        end
      end else if (access_s) begin
        if (pready_q) begin
          state_q <= IDLE;
        end else begin
          state_q <= ACCESS;
          if (wait_done) begin
            pready_q  <= 1'b1;
            pslverr_q <= err_q;
            prdata_q  <= (err_q || write_q) ? '0 : rd_data;
          end
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

  apb4_mem #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .we_i    (mem_we),
    .widx_i  (idx_q),
    .wstrb_i (PSTRB),
    .wdata_i (PWDATA),
    .ridx_i  (rd_idx),
    .rdata_o (rd_data)
  );

  assign PREADY  = pready_q;
  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb4_slave.sv
// Bench for apb4_slave: a word-array model predicts per-cycle PREADY/PRDATA/PSLVERR.
module tb_apb4_slave;
  import apb4_pkg::*;

`ifdef APB_WAIT_STATE_EN
  localparam int WAITS = 2;
  localparam int XFER_CYC = 4;
`else
  localparam int WAITS = 0;
  localparam int XFER_CYC = 2;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  int tests = 0;
  int fails = 0;

  logic [31:0] model_mem [APB_MEM_DEPTH];
  bit          chk_en = 1'b1;
  logic        exp_pready = 1'b0;
  logic [31:0] exp_prdata = 32'h0;
  logic        exp_pslverr = 1'b0;

  apb4_slave #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .MEM_DEPTH   (256),
    .WAIT_CYCLES (2)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PPROT   (PPROT),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_exp(input logic r, input logic [31:0] d, input logic e);
    exp_pready  = r;
    exp_prdata  = d;
    exp_pslverr = e;
  endtask

  always @(negedge PCLK) begin
    if (chk_en) begin
      chk("cyc_pready", {31'h0, PREADY}, {31'h0, exp_pready});
      chk("cyc_prdata", PRDATA, exp_prdata);
      chk("cyc_pslverr", {31'h0, PSLVERR}, {31'h0, exp_pslverr});
    end
  end

  task automatic bus_idle();
    PSEL = 1'b0;
    PENABLE = 1'b0;
    set_exp(1'b0, 32'h0, 1'b0);
  endtask

  // Caller is 1 time unit after a rising edge; returns the same way after completion.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output bit er,
                      output int cyc);
    bit          bad;
    bit          done;
    logic [31:0] exp_rd;
    logic [31:0] mask;
    bad    = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(APB_MEM_DEPTH));
    exp_rd = (bad || wr) ? 32'h0 : model_mem[addr[9:2]];
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = wd; PSTRB = st; PPROT = 3'($urandom);
    set_exp(1'b0, 32'h0, 1'b0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cyc = 1; done = 1'b0; rd = 32'h0; er = 1'b0;
    for (int k = 0; k <= WAITS + 4 && !done; k++) begin
      if (k == WAITS) set_exp(1'b1, exp_rd, bad);
      else set_exp(1'b0, 32'h0, 1'b0);
      @(negedge PCLK);
      if (PREADY === 1'b1) begin
        done = 1'b1;
        rd = PRDATA;
        er = PSLVERR;
      end
      @(posedge PCLK); #1;
      cyc++;
    end
    chk("xfer_pready_seen", {31'h0, done}, 32'h1);
    chk("xfer_cycles", cyc, 2 + WAITS);
    if (wr && !bad) begin
      mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
      model_mem[addr[9:2]] = (model_mem[addr[9:2]] & ~mask) | (wd & mask);
    end
    bus_idle();
  endtask

  // Setup phase followed by PSEL dropping: nothing may be written.
  task automatic abort_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = wd; PSTRB = 4'hF; PPROT = 3'h0;
    set_exp(1'b0, 32'h0, 1'b0);
    @(posedge PCLK); #1;
    chk_en = 1'b0;
    bus_idle();
    @(posedge PCLK); #1;
    chk_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          er;
    int          cyc;
    logic [31:0] addr;
    int          r;

    foreach (model_mem[i]) model_mem[i] = 32'h0;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PSTRB = 0; PPROT = 0;
    PRESETn = 1'b1;
    #1 PRESETn = 1'b0;
    #2;
    chk("rst_pready", {31'h0, PREADY}, 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
    #28 PRESETn = 1'b1;
    @(posedge PCLK); #1;

    xfer(0, 32'h10, 32'h0, 4'hF, rd, er, cyc);
    chk("rd_0x10_after_rst", rd, 32'h0000_0000);

    xfer(1, 32'h04, 32'hDEAD_BEEF, 4'hF, rd, er, cyc);
    xfer(0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
    chk("rd_0x04", rd, 32'hDEAD_BEEF);
    chk("rd_0x04_err", {31'h0, er}, 32'h0);

    xfer(1, 32'h08, 32'h1122_3344, 4'hF, rd, er, cyc);
    xfer(1, 32'h08, 32'hAABB_CCDD, 4'b0101, rd, er, cyc);
    xfer(0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
    chk("rd_0x08_strobed", rd, 32'h11BB_33DD);

    xfer(1, 32'h402, 32'hFFFF_FFFF, 4'hF, rd, er, cyc);
    chk("err_wr_misaligned", {31'h0, er}, 32'h1);
    xfer(1, 32'h400, 32'hFFFF_FFFF, 4'hF, rd, er, cyc);
    chk("err_wr_oob", {31'h0, er}, 32'h1);
    xfer(0, 32'h400, 32'h0, 4'h0, rd, er, cyc);
    chk("err_rd_oob", {31'h0, er}, 32'h1);
    chk("err_rd_oob_data", rd, 32'h0);
    xfer(0, 32'h00, 32'h0, 4'h0, rd, er, cyc);
    chk("rd_0x00_unchanged", rd, 32'h0);
    xfer(0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
    chk("rd_0x04_unchanged", rd, 32'hDEAD_BEEF);

    xfer(1, 32'h0C, 32'hCAFE_F00D, 4'hF, rd, er, cyc);
    chk("b2b_wr1_cycles", cyc, XFER_CYC);
    xfer(1, 32'h10, 32'h0BAD_C0DE, 4'hF, rd, er, cyc);
    chk("b2b_wr2_cycles", cyc, XFER_CYC);
    xfer(0, 32'h0C, 32'h0, 4'h0, rd, er, cyc);
    chk("b2b_rd_cycles", cyc, XFER_CYC);
    chk("b2b_rd_0x0C", rd, 32'hCAFE_F00D);

    abort_xfer(1, 32'h0C, 32'h1234_5678);
    xfer(0, 32'h0C, 32'h0, 4'h0, rd, er, cyc);
    chk("abort_no_write", rd, 32'hCAFE_F00D);

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 15));
      if (r < 8) addr = {22'h0, 6'($urandom_range(0, 15)), 2'b00};
      else if (r < 12) addr = {22'h0, 8'($urandom), 2'b00};
      else if (r < 14) addr = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
      else if (r < 15) addr = 32'h400 + 32'($urandom_range(0, 63)) * 4;
      else addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 24) == 0) begin
        abort_xfer(1'($urandom), addr, $urandom);
      end else begin
        xfer(1'($urandom), addr, $urandom, 4'($urandom), rd, er, cyc);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge PCLK); #1;
      end
    end

    xfer(1, 32'h14, 32'h5555_AAAA, 4'hF, rd, er, cyc);
    xfer(0, 32'h14, 32'h0, 4'h0, rd, er, cyc);
    chk("rd_0x14_before_rst", rd, 32'h5555_AAAA);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h14;
    PWDATA = 32'h1234_5678; PSTRB = 4'hF;
    set_exp(1'b0, 32'h0, 1'b0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    chk_en = 1'b0;
    chk("pre_rst_pready", {31'h0, PREADY}, (WAITS == 0) ? 32'h1 : 32'h0);
    #1 PRESETn = 1'b0;
    #1;
    chk("mid_rst_pready", {31'h0, PREADY}, 32'h0);
    chk("mid_rst_prdata", PRDATA, 32'h0);
    chk("mid_rst_pslverr", {31'h0, PSLVERR}, 32'h0);
    bus_idle();
    foreach (model_mem[i]) model_mem[i] = 32'h0;
    chk_en = 1'b1;
    #28 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(0, 32'h14, 32'h0, 4'h0, rd, er, cyc);
    chk("rd_0x14_after_rst", rd, 32'h0);
    xfer(0, 32'h0C, 32'h0, 4'h0, rd, er, cyc);
    chk("rd_0x0C_after_rst", rd, 32'h0);
    @(posedge PCLK); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
